// File: rtl/shreg_serial_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shreg_serial_sched_pkg
// Brief   : Shared state encoding and default sizing for the round-robin
//           serial scheduler and its bench.
// Revision: 1.0 - initial release
// ============================================================================
package shreg_serial_sched_pkg;

  // Default sizing: one byte per frame, two requesters, one idle cycle
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;
  localparam int DEF_GAP   = 1;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage : shreg_serial_sched_pkg
`default_nettype wire

// File: rtl/shreg_serial_sched_piso.sv
`default_nettype none
// ============================================================================
// Module  : shreg_piso
// Brief   : WIDTH-bit parallel-in / serial-out register, MSB first,
//           zero fill. Priority: clr over load over shift.
// Revision: 1.0 - initial release
// ============================================================================
module shreg_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             ser_out
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Next register contents: synchronous clear, parallel load or left shift
  always_comb begin
    shreg_d = shreg_q;
    if (clr) begin
      shreg_d = '0;
    end else if (load) begin
      shreg_d = load_data;
    end else if (shift) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Storage with asynchronous clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign ser_out = shreg_q[WIDTH-1];

endmodule : shreg_piso
`default_nettype wire

// File: rtl/shreg_serial_sched.sv
`default_nettype none
// ============================================================================
// Module  : shreg_serial_sched
// Brief   : Round-robin scheduler sharing one parallel-load/serial-out
//           shift register among NREQ valid/ready requesters, with framing
//           strobes, a programmable idle gap and a synchronous abort.
// Revision: 1.0 - initial release
// ============================================================================
module shreg_serial_sched
  import shreg_serial_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int GAP   = DEF_GAP
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    abort,
  output logic                    busy,
  output logic                    ser_out,
  output logic                    ser_valid,
  output logic                    ser_first,
  output logic                    ser_last,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int BW = $clog2(WIDTH);
  localparam int PW = $clog2(NREQ);
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0]    S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0]    S_SHIFT  = 2'(ST_SHIFT);
  localparam logic [1:0]    S_GAP    = 2'(ST_GAP);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_EXT = (PW + 1)'(NREQ);

  logic [1:0]       state_q,    state_d;
  logic [BW-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [CW-1:0]    gap_cnt_q,  gap_cnt_d;
  logic [PW-1:0]    rr_ptr_q,   rr_ptr_d;
  logic [PW-1:0]    grant_id_q, grant_id_d;

  logic [PW-1:0]    win_id;
  logic             win_found;
  logic             grant;
  logic             piso_clr;
  logic             piso_load;
  logic             piso_shift;
  logic             piso_msb;
  logic [WIDTH-1:0] win_data;

  // Round-robin search: first valid requester at or above the pointer, wrapping
  always_comb begin : p_arb
    logic [PW:0] sum;
    win_found = 1'b0;
    win_id    = rr_ptr_q;
    sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW + 1)'(k);
      if (sum >= NREQ_EXT) begin
        sum = sum - NREQ_EXT;
      end
      if (!win_found && req_valid[sum[PW-1:0]]) begin
        win_found = 1'b1;
        win_id    = sum[PW-1:0];
      end
    end
  end

  assign grant    = win_found && (state_q == S_IDLE) && !abort;
  assign win_data = req_data[win_id*WIDTH +: WIDTH];

  // One-hot acknowledge; held low while reset is asserted so nothing leaks out
  always_comb begin
    req_ready = '0;
    if (grant && clr_n) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Scheduler next-state, counters and shift-register controls
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    piso_clr   = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          piso_load  = 1'b1;
          grant_id_d = win_id;
          rr_ptr_d   = (win_id == PTR_LAST) ? '0 : win_id + 1'b1;
          bit_cnt_d  = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          piso_clr  = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          piso_shift = 1'b1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = (GAP > 0) ? S_GAP : S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          piso_clr  = 1'b1;
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scheduler state registers with asynchronous reset
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  shreg_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk       (clk),
    .clr_n     (clr_n),
    .clr       (piso_clr),
    .load      (piso_load),
    .load_data (win_data),
    .shift     (piso_shift),
    .ser_out   (piso_msb)
  );

  // Framing outputs are forced low outside SHIFT
  assign ser_valid = (state_q == S_SHIFT);
  assign ser_out   = ser_valid & piso_msb;
  assign ser_first = ser_valid && (bit_cnt_q == '0);
  assign ser_last  = ser_valid && (bit_cnt_q == BIT_LAST);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign grant_id  = grant_id_q;

endmodule : shreg_serial_sched
`default_nettype wire

// File: tb/tb_shreg_serial_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_shreg_serial_sched
// Brief   : Directed self-checking bench for shreg_serial_sched (GAP=1 and
//           GAP=0 instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_shreg_serial_sched;
  import shreg_serial_sched_pkg::*;

  localparam int W = 8;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           clr_n;
  logic [N-1:0]   rv, rr;
  logic [N*W-1:0] rd;
  logic           abort;
  logic           busy, so, sv, sf, sl;
  logic [0:0]     gid;

  logic [N-1:0]   rv0, rr0;
  logic [N*W-1:0] rd0;
  logic           busy0, so0, sv0, sf0, sl0;
  logic [0:0]     gid0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  shreg_serial_sched #(.WIDTH(W), .NREQ(N), .GAP(1)) dut (
    .clk(clk), .clr_n(clr_n), .req_valid(rv), .req_data(rd), .req_ready(rr),
    .abort(abort), .busy(busy), .ser_out(so), .ser_valid(sv),
    .ser_first(sf), .ser_last(sl), .grant_id(gid)
  );

  shreg_serial_sched #(.WIDTH(W), .NREQ(N), .GAP(0)) dut0 (
    .clk(clk), .clr_n(clr_n), .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
    .abort(1'b0), .busy(busy0), .ser_out(so0), .ser_valid(sv0),
    .ser_first(sf0), .ser_last(sl0), .grant_id(gid0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an acknowledge, checks it, then advances past the grant edge
  task automatic grant_wait(input logic [N-1:0] exp_rdy, input string tag);
    int n;
    n = 0;
    #1;
    while (rr == '0 && n < 30) begin
      step();
      #1;
      n++;
    end
    chk(tag, 32'(rr), 32'(exp_rdy));
    step();
  endtask

  // Collects one WIDTH-bit frame starting at its first bit; ends in the cycle after the last bit
  task automatic run_frame(input logic [7:0] ed, input logic [0:0] eg, input string tag,
                           output int t_first);
    logic [7:0] cap, fm, lm;
    int nv, nb;
    bit gok;
    cap = '0; fm = '0; lm = '0; nv = 0; nb = 0; gok = 1'b1;
    t_first = cyc;
    for (int i = 0; i < W; i++) begin
      cap = {cap[6:0], so};
      fm  = {fm[6:0], sf};
      lm  = {lm[6:0], sl};
      nv += int'(sv);
      nb += int'(busy);
      if (gid !== eg) gok = 1'b0;
      step();
    end
    chk({tag, "_data"},  32'(cap), 32'(ed));
    chk({tag, "_first"}, 32'(fm),  32'h80);
    chk({tag, "_last"},  32'(lm),  32'h01);
    chk({tag, "_valid"}, 32'(nv),  32'd8);
    chk({tag, "_busy"},  32'(nb),  32'd8);
    chk({tag, "_gid"},   32'(gok), 32'd1);
  endtask

  initial begin
    int t, tprev, nf, gaps;
    logic [3:0] cap4;

    clr_n = 1'b0; rv = 2'b01; rd = '0; abort = 1'b0;
    rv0 = 2'b00; rd0 = '0;

    // Reset: everything low, acknowledge suppressed even with a valid request
    #2;
    chk("rst_ready", 32'(rr), 32'd0);
    chk("rst_outs",  32'({busy, so, sv, sf, sl, gid}), 32'd0);
    step(); step();
    clr_n = 1'b1;

    // Single request 0xA5 from requester 0
    rd[7:0] = 8'hA5;
    grant_wait(2'b01, "t1_ready");
    rv = 2'b00;
    run_frame(8'hA5, 1'b0, "t1", t);
    chk("t1_gap_valid", 32'(sv),   32'd0);
    chk("t1_gap_busy",  32'(busy), 32'd1);
    step();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Fairness: pointer moved past requester 0, so requester 1 wins
    rd = {8'h3C, 8'hC3};
    rv = 2'b11;
    grant_wait(2'b10, "fair_ready");
    run_frame(8'h3C, 1'b1, "fair", t);

    // Contention: strict alternation, first bits spaced WIDTH+GAP+1 apart
    rd = {8'hF0, 8'h0F};
    tprev = 0;
    for (int f = 0; f < 4; f++) begin
      grant_wait((f % 2 == 0) ? 2'b01 : 2'b10, "cont_ready");
      run_frame((f % 2 == 0) ? 8'h0F : 8'hF0, 1'((f % 2)), "cont", t);
      if (f > 0) chk("cont_spacing", 32'(t - tprev), 32'd10);
      tprev = t;
    end

    // Abort during bit index 3 of 0xFF
    rv = 2'b01;
    rd[7:0] = 8'hFF;
    grant_wait(2'b01, "abt_ready");
    cap4 = '0;
    for (int i = 0; i < 4; i++) begin
      cap4 = {cap4[2:0], so};
      if (i == 3) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    #1;
    chk("abt_bits",  32'(cap4), 32'hF);
    chk("abt_valid", 32'(sv),   32'd0);
    chk("abt_busy",  32'(busy), 32'd0);
    chk("abt_regrant", 32'(rr), 32'd1);
    step();
    chk("abt_next_first", 32'({sv, sf, gid}), 32'b110);

    // Async reset during bit 5 of the re-granted 0xFF frame
    for (int i = 0; i < 5; i++) step();
    chk("ar_pre", 32'({sv, so}), 32'b11);
    rv = 2'b11;
    #2;
    clr_n = 1'b0;
    #1;
    chk("ar_drop", 32'({sv, busy, so, rr}), 32'd0);
    step(); step();
    clr_n = 1'b1;
    #1;
    chk("ar_rel_ready", 32'(rr), 32'd1);
    step();
    chk("ar_rel_grant", 32'({sv, sf, gid}), 32'b110);
    rv = 2'b00;
    for (int i = 0; i < 10; i++) step();

    // GAP=0 back-to-back frames from a single requester
    rd0[7:0] = 8'h81;
    rv0 = 2'b01;
    tprev = 0; nf = 0; gaps = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (nf < 3) begin
        if (sf0) begin
          if (nf > 0) chk("g0_spacing", 32'(cyc - tprev), 32'd9);
          tprev = cyc;
          nf++;
        end else if (nf > 0 && !sv0) begin
          gaps++;
        end
      end
    end
    chk("g0_frames", 32'(nf),   32'd3);
    chk("g0_gaps",   32'(gaps), 32'd2);
    rv0 = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shreg_serial_sched
`default_nettype wire

// File: doc/shreg_serial_sched.md
Name: shreg_serial_sched

Overview:
- Round-robin scheduler that shares one WIDTH-bit parallel-load/serial-out shift register between NREQ requesters.
- Each requester offers a word with valid/ready. The block grants one requester, loads its word in parallel, then shifts it out MSB-first with framing strobes.
- A programmable idle gap follows each frame.
- Sits between word-producing logic and the single-bit serial link built on the team's shift-register primitive.

Parameters:
- WIDTH, 8, bits per frame (>=2).
- NREQ, 2, number of requesters (>=2).
- GAP, 1, idle cycles after each frame's last bit (>=0).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a word pending.
- req_data  in  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot; word i accepted at this rising edge.
- abort  in  1  synchronous; kill current frame.
- busy  out  1  high in SHIFT or GAP.
- ser_out  out  1  current serial bit (MSB first).
- ser_valid  out  1  ser_out carries a frame bit.
- ser_first  out  1  first bit of frame.
- ser_last  out  1  last bit of frame.
- grant_id  out  $clog2(NREQ)  owner of the current frame; meaningful while ser_valid.

Behaviour:
- Reset (clr_n=0, takes effect immediately):
  - state=IDLE; shift reg=0; bit counter=0; gap counter=0; rr pointer=0.
  - All outputs 0, including req_ready.
- States: IDLE, SHIFT, GAP.
- IDLE, arbitration:
  - Winner = first i with req_valid[i]=1, searching from rr pointer upward, modulo NREQ.
  - req_ready[winner]=1, combinational from req_valid, IDLE and !abort; req_ready=0 in all other states.
  - At that edge: shift reg <= req_data[winner]; grant_id <= winner; rr pointer <= (winner+1) mod NREQ; bit counter <= 0; state -> SHIFT.
  - No valid, or abort=1: remain in IDLE, no grant, pointer unchanged.
- SHIFT:
  - ser_valid=1; ser_out = shift reg MSB.
  - ser_first=1 when bit counter=0; ser_last=1 when bit counter=WIDTH-1.
  - Each cycle: shift left, zero-fill, counter+1.
  - After the bit at counter WIDTH-1: go to GAP if GAP>0 (gap counter=0), else to IDLE.
- GAP:
  - ser_valid=0, ser_out=0; counts GAP cycles, then goes to IDLE.
- Latency and throughput:
  - Accept edge at cycle t: bits appear in cycles t+1..t+WIDTH.
  - Minimum spacing between consecutive ser_first pulses is WIDTH+GAP+1 cycles (one IDLE arbitration cycle always).
- ser_out, ser_first, ser_last are 0 whenever ser_valid=0.
- busy=1 in SHIFT and GAP.
- abort:
  - In SHIFT or GAP: next state IDLE; remaining bits discarded; shift reg cleared; rr pointer keeps its post-grant value.
  - Aborted frame is not re-sent; the requester has already been acked.
- req_valid may fall without a grant; it is sampled only in IDLE.
- req_data is sampled only on the req_ready edge.
- Simultaneous req_valid plus a frame in progress: request waits, no ready, until IDLE.
- Async reset mid-frame: outputs drop without waiting for a clock edge. On release, first possible grant is the first rising edge with clr_n=1 and IDLE conditions met, with pointer=0.

Decomposition:
- Shared package (used by this block and its bench):
  - state enum: IDLE, SHIFT, GAP.
  - default WIDTH/NREQ/GAP constants.
- One natural sub-module, shreg_piso:
  - WIDTH-bit parallel-in/serial-out register with ports load, load_data, shift, ser_out, clr.
  - Async clear on clr_n.
- The scheduler FSM, round-robin arbiter and counters stay in shreg_serial_sched.

Test Plan:
- Single request, WIDTH=8, GAP=1:
  - Stimulus: req_valid=01, data0=0xA5.
  - Response: req_ready=01 at edge t. ser_out = 1,0,1,0,0,1,0,1 in cycles t+1..t+8. ser_first at t+1, ser_last at t+8, grant_id=0. busy high t+1..t+9; IDLE at t+10.
- Contention:
  - Stimulus: req_valid=11 held, data0=0x0F, data1=0xF0.
  - Response: grants alternate 0,1,0,1. Frames 0x0F, 0xF0, 0x0F, 0xF0. ser_first spacing exactly 10 cycles.
- Fairness after idle:
  - Stimulus: grant requester 0 alone, then raise req_valid=11.
  - Response: requester 1 wins first (pointer=1).
- Abort mid-frame:
  - Stimulus: abort=1 during bit index 3 of 0xFF.
  - Response: bits 0..3 output as 1. Next cycle ser_valid=0, busy=0, state IDLE. A pending request is granted on the cycle after.
- Async reset mid-frame:
  - Stimulus: drop clr_n between edges during bit 5.
  - Response: ser_valid, busy, ser_out, req_ready go to 0 before the next edge. After release with req_valid=11, grant goes to 0.
- GAP=0 back-to-back:
  - Stimulus: continuous req_valid=01.
  - Response: ser_first every 9 cycles; exactly one cycle with ser_valid=0 between frames.
